sync_fifo_flex: RTL and testbench
=================================

// Module: sync_fifo_flex
// PURPOSE
//  Parametrised single-clock FIFO; successor to the basic 8x8 sync FIFO. Adds
//  arbitrary (incl. non-power-of-2) depth, selectable standard/first-word-fall-through
//  read mode, occupancy count, programmable almost-full/almost-empty, sync flush
//  and sticky overflow/underflow. Used as generic buffering between datapath stages.
// PARAMETERS
//  DATA_WIDTH  8  data word width, >=1
//  DEPTH       8  number of entries, >=2, any integer
//  FWFT        0  0 = standard (registered read, 1-cycle latency); 1 = first-word-fall-through
//  AF_THRESH   6  almost_full asserted when count >= AF_THRESH (1..DEPTH)
//  AE_THRESH   1  almost_empty asserted when count <= AE_THRESH (0..DEPTH-1)
//  Local: AW = $clog2(DEPTH) (min 1); CW = $clog2(DEPTH+1)
// PORTS
//  clk           in   1           clock, rising edge
//  rst_n         in   1           reset, asynchronous, active-low
//  flush         in   1           sync clear of pointers/count/flags/errors
//  wr_en         in   1           write request
//  wr_data       in   DATA_WIDTH  write data
//  rd_en         in   1           read request (FWFT: pop head)
//  rd_data       out  DATA_WIDTH  read data
//  full          out  1           count == DEPTH
//  empty         out  1           count == 0
//  almost_full   out  1           count >= AF_THRESH
//  almost_empty  out  1           count <= AE_THRESH
//  count         out  CW          current occupancy, 0..DEPTH
//  overflow      out  1           sticky: write attempted while full
//  underflow     out  1           sticky: read attempted while empty
// BEHAVIOUR
//  - Reset: pointers=0, count=0, empty=1, almost_empty=1, full=0, almost_full=0,
//    overflow=0, underflow=0, rd_data=0. Memory array is NOT reset.
//  - wr_acc = wr_en & ~full; rd_acc = rd_en & ~empty; decisions use registered flags.
//  - Full + wr_en + rd_en: read accepted, write rejected, overflow set.
//  - Empty + wr_en + rd_en: write accepted, read rejected, underflow set.
//  - Both accepted: count unchanged, both pointers advance.
//  - Pointers advance only on accept; wrap DEPTH-1 -> 0 (explicit compare, not
//    natural overflow), so non-power-of-2 depths are exact.
//  - count: +1 on wr_acc only, -1 on rd_acc only; never leaves 0..DEPTH.
//  - All flags registered, computed from next-count; valid the cycle after the op.
//  - Standard mode: on rd_acc, rd_data <= mem[rd_ptr] at that edge (data visible
//    1 cycle after rd_en); otherwise rd_data holds its value.
//  - FWFT mode: rd_data = mem[rd_ptr] combinationally; head valid whenever
//    empty=0; rd_en pops. Word written at edge N is visible, empty=0, after edge N.
//  - flush (priority over wr/rd in the same cycle): pointers=0, count=0, flags to
//    reset values, overflow/underflow cleared; memory and std-mode rd_data untouched.
//  - overflow/underflow stay set until flush or reset.
//  - Async reset mid-operation: immediate return to reset state; no partial writes.
// STRUCTURE
//  - fifo_pkg: fifo_mode_e {FIFO_STD, FIFO_FWFT}; clog2 helper function.
//  - Sub-module fifo_ram_sdp: DEPTH x DATA_WIDTH simple dual-port array,
//    sync write, async read; read register/mux lives in sync_fifo_flex.
//  - Elaboration check: AF_THRESH/AE_THRESH in range, DEPTH>=2.
// TESTING (run FWFT=0 and FWFT=1; DEPTH=8 and DEPTH=5)
//  1 Reset then 8 writes 0x11..0x88 -> count 1..8, almost_full at count 6, full
//    after 8th; 9th write -> data dropped, overflow=1, count stays 8.
//  2 Drain 8 -> rd_data 0x11..0x88 in order (std: 1-cycle lag; FWFT: 0x11 visible
//    before first rd_en); empty=1 after last; extra read -> underflow=1.
//  3 Fill 3, then 20 cycles wr_en=rd_en=1 -> count stays 3, in-order data, pointers
//    wrap cleanly (DEPTH=5 wraps at 4->0).
//  4 Full + wr_en + rd_en -> read ok, write rejected, overflow=1, count=7; empty +
//    wr_en + rd_en -> write ok, underflow=1, count=1.
//  5 Fill 4, assert flush with wr_en=1 -> next cycle count=0, empty=1, errors
//    cleared, written word discarded.
//  6 Assert rst_n=0 mid-burst, asynchronous to clk -> all outputs at reset values
//    before next edge; resume writes work.

Source files
------------

// File: rtl/sync_fifo_flex_pkg.sv
// rtl/sync_fifo_flex_pkg.sv - shared types and helpers for the flexible sync FIFO
package sync_fifo_flex_pkg;

    typedef enum logic {
        FIFO_STD  = 1'b0,
        FIFO_FWFT = 1'b1
    } fifo_mode_e;

    // Ceiling log2; usable in parameter expressions.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/sync_fifo_flex_if.sv
// rtl/sync_fifo_flex_if.sv - write/read/status bundle between a producer-consumer and the FIFO
interface sync_fifo_flex_if #(
    parameter int DATA_WIDTH = 8,
    parameter int CW         = 4
);
    logic                  flush;
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [CW-1:0]         count;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output flush, wr_en, wr_data, rd_en,
        input  rd_data, full, empty, almost_full, almost_empty, count, overflow, underflow
    );

    modport slave (
        input  flush, wr_en, wr_data, rd_en,
        output rd_data, full, empty, almost_full, almost_empty, count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_flex_ram_sdp.sv
// rtl/sync_fifo_flex_ram_sdp.sv - simple dual-port storage, synchronous write, asynchronous read
module fifo_ram_sdp #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int AW         = 3
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/sync_fifo_flex.sv
// rtl/sync_fifo_flex.sv - single-clock FIFO with any depth, std/FWFT read, thresholds, flush, sticky errors
module sync_fifo_flex
    import sync_fifo_flex_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int FWFT       = 0,
    parameter int AF_THRESH  = 6,
    parameter int AE_THRESH  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    sync_fifo_flex_if.slave  bus
);
    localparam int         AW   = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH);
    localparam int         CW   = clog2(DEPTH + 1);
    localparam fifo_mode_e MODE = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;

    generate
        if (DEPTH < 2 || AF_THRESH < 1 || AF_THRESH > DEPTH ||
            AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_param
            $error("sync_fifo_flex: DEPTH/AF_THRESH/AE_THRESH out of range");
        end
    endgenerate

    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic [CW-1:0]         count_q, count_nxt;
    logic                  full_q, empty_q, afull_q, aempty_q, ovf_q, unf_q;
    logic [DATA_WIDTH-1:0] ram_rd_data, rd_q;
    logic                  wr_acc, rd_acc, ram_we;

    assign wr_acc = bus.wr_en & ~full_q;
    assign rd_acc = bus.rd_en & ~empty_q;
    // Flush discards a same-cycle write; reset blocks stray writes into storage.
    assign ram_we = wr_acc & ~bus.flush & rst_n;

    // Explicit wrap keeps non-power-of-2 depths exact.
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    always_comb begin
        count_nxt = count_q;
        if (wr_acc && !rd_acc)      count_nxt = count_q + CW'(1);
        else if (rd_acc && !wr_acc) count_nxt = count_q - CW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            rd_q     <= '0;
        end else if (bus.flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr <= ptr_inc(wr_ptr);
            if (rd_acc) begin
                rd_ptr <= ptr_inc(rd_ptr);
                rd_q   <= ram_rd_data;
            end
            count_q  <= count_nxt;
            full_q   <= (count_nxt == CW'(DEPTH));
            empty_q  <= (count_nxt == '0);
            afull_q  <= (count_nxt >= CW'(AF_THRESH));
            aempty_q <= (count_nxt <= CW'(AE_THRESH));
            if (bus.wr_en && full_q)  ovf_q <= 1'b1;
            if (bus.rd_en && empty_q) unf_q <= 1'b1;
        end
    end

    fifo_ram_sdp #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .AW         (AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (wr_ptr),
        .wdata (bus.wr_data),
        .raddr (rd_ptr),
        .rdata (ram_rd_data)
    );

    assign bus.rd_data      = (MODE == FIFO_FWFT) ? ram_rd_data : rd_q;
    assign bus.full         = full_q;
    assign bus.empty        = empty_q;
    assign bus.almost_full  = afull_q;
    assign bus.almost_empty = aempty_q;
    assign bus.count        = count_q;
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = unf_q;
endmodule

// File: tb/tb_sync_fifo_flex.sv
// tb/tb_sync_fifo_flex.sv - bench driving a DEPTH=8 standard FIFO and a DEPTH=5 FWFT FIFO in lockstep
module tb_sync_fifo_flex;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       flush = 1'b0, wr_en = 1'b0, rd_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    sync_fifo_flex_if #(.DATA_WIDTH(8), .CW(4)) bus_a ();
    sync_fifo_flex_if #(.DATA_WIDTH(8), .CW(3)) bus_b ();

    assign bus_a.flush = flush;  assign bus_b.flush = flush;
    assign bus_a.wr_en = wr_en;  assign bus_b.wr_en = wr_en;
    assign bus_a.rd_en = rd_en;  assign bus_b.rd_en = rd_en;
    assign bus_a.wr_data = wr_data;  assign bus_b.wr_data = wr_data;

    sync_fifo_flex #(.DATA_WIDTH(8), .DEPTH(8), .FWFT(0), .AF_THRESH(6), .AE_THRESH(1))
        dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a.slave));
    sync_fifo_flex #(.DATA_WIDTH(8), .DEPTH(5), .FWFT(1), .AF_THRESH(4), .AE_THRESH(2))
        dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b.slave));

    logic [3:0] o_count [2];
    logic [7:0] o_data  [2];
    logic       o_full [2], o_empty [2], o_af [2], o_ae [2], o_ovf [2], o_unf [2];

    assign o_count[0] = bus_a.count;          assign o_count[1] = {1'b0, bus_b.count};
    assign o_data[0]  = bus_a.rd_data;        assign o_data[1]  = bus_b.rd_data;
    assign o_full[0]  = bus_a.full;           assign o_full[1]  = bus_b.full;
    assign o_empty[0] = bus_a.empty;          assign o_empty[1] = bus_b.empty;
    assign o_af[0]    = bus_a.almost_full;    assign o_af[1]    = bus_b.almost_full;
    assign o_ae[0]    = bus_a.almost_empty;   assign o_ae[1]    = bus_b.almost_empty;
    assign o_ovf[0]   = bus_a.overflow;       assign o_ovf[1]   = bus_b.overflow;
    assign o_unf[0]   = bus_a.underflow;      assign o_unf[1]   = bus_b.underflow;

    // Reference model: a queue per FIFO, sticky error bits, last word popped (std mode).
    logic [7:0] qa [$];
    logic [7:0] qb [$];
    logic [7:0] rexp [2];
    logic       movf [2], munf [2];
    int         dep [2] = '{8, 5};
    int         afth [2] = '{6, 4};
    int         aeth [2] = '{1, 2};

    function automatic int msize(input int i);
        return (i == 0) ? qa.size() : qb.size();
    endfunction

    function automatic logic [7:0] mhead(input int i);
        return (i == 0) ? qa[0] : qb[0];
    endfunction

    task automatic model_clear();
        qa.delete(); qb.delete();
        for (int i = 0; i < 2; i++) begin
            rexp[i] = 8'h00; movf[i] = 1'b0; munf[i] = 1'b0;
        end
    endtask

    task automatic model_step(input int i, input bit fl, input bit we, input logic [7:0] wd, input bit re);
        int n;
        logic [7:0] v;
        n = msize(i);
        if (fl) begin
            if (i == 0) qa.delete(); else qb.delete();
            movf[i] = 1'b0; munf[i] = 1'b0;
            return;
        end
        if (re && n == 0)      munf[i] = 1'b1;
        if (we && n == dep[i]) movf[i] = 1'b1;
        if (re && n != 0) begin
            if (i == 0) rexp[0] = qa.pop_front(); else v = qb.pop_front();
        end
        if (we && n != dep[i]) begin
            if (i == 0) qa.push_back(wd); else qb.push_back(wd);
        end
    endtask

    task automatic tick(input bit fl, input bit we, input logic [7:0] wd, input bit re);
        flush = fl; wr_en = we; wr_data = wd; rd_en = re;
        @(posedge clk);
        model_step(0, fl, we, wd, re);
        model_step(1, fl, we, wd, re);
        #1;
        flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #7;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({o_full[i], o_empty[i], o_af[i], o_ae[i], o_ovf[i], o_unf[i]} !== 6'b010100 || o_count[i] !== 4'd0) begin
                errors++;
                $display("FAIL reset_state[%0d] flags=%b count=%0d expected flags=010100 count=0", i,
                         {o_full[i], o_empty[i], o_af[i], o_ae[i], o_ovf[i], o_unf[i]}, o_count[i]);
            end
        end
        checks++;
        if (o_data[0] !== 8'h00) begin errors++; $display("FAIL reset_rd_data got %h expected 00", o_data[0]); end
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
    endtask

    task automatic test_fill();
        for (int k = 1; k <= 9; k++) begin
            tick(1'b0, 1'b1, 8'(k * 17), 1'b0);
            checks++;
            if (o_count[0] !== 4'((k > 8) ? 8 : k)) begin errors++; $display("FAIL fill_count_a k=%0d got %0d", k, o_count[0]); end
            checks++;
            if ({o_af[0], o_full[0], o_ovf[0]} !== {k >= 6, k >= 8, k == 9}) begin
                errors++; $display("FAIL fill_flags_a k=%0d af/full/ovf=%b", k, {o_af[0], o_full[0], o_ovf[0]});
            end
            checks++;
            if (o_count[1] !== 4'((k > 5) ? 5 : k) || o_ovf[1] !== (k > 5)) begin
                errors++; $display("FAIL fill_b k=%0d count=%0d ovf=%b", k, o_count[1], o_ovf[1]);
            end
        end
    endtask

    task automatic test_drain();
        logic [7:0] exp;
        for (int k = 1; k <= 8; k++) begin
            exp = 8'(k * 17);
            if (k <= 5) begin
                checks++;
                if (o_data[1] !== exp) begin errors++; $display("FAIL drain_fwft_head k=%0d got %h expected %h", k, o_data[1], exp); end
            end
            tick(1'b0, 1'b0, 8'h00, 1'b1);
            checks++;
            if (o_data[0] !== exp) begin errors++; $display("FAIL drain_std_data k=%0d got %h expected %h", k, o_data[0], exp); end
            checks++;
            if (o_empty[0] !== (k == 8)) begin errors++; $display("FAIL drain_empty_a k=%0d got %b", k, o_empty[0]); end
        end
        tick(1'b0, 1'b0, 8'h00, 1'b1);
        checks++;
        if ({o_unf[0], o_unf[1], o_empty[0]} !== 3'b111 || o_data[0] !== 8'h88) begin
            errors++; $display("FAIL drain_underflow unf=%b%b empty=%b data=%h expected 1 1 1 88",
                               o_unf[0], o_unf[1], o_empty[0], o_data[0]);
        end
    endtask

    task automatic test_back_to_back();
        tick(1'b1, 1'b0, 8'h00, 1'b0);
        for (int k = 0; k < 3; k++) tick(1'b0, 1'b1, 8'(8'hA0 + k), 1'b0);
        for (int c = 0; c < 20; c++) begin
            tick(1'b0, 1'b1, 8'($urandom), 1'b1);
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (o_count[i] !== 4'd3) begin errors++; $display("FAIL b2b_count[%0d] c=%0d got %0d expected 3", i, c, o_count[i]); end
            end
            checks++;
            if (o_data[0] !== rexp[0] || o_data[1] !== mhead(1)) begin
                errors++; $display("FAIL b2b_data c=%0d got %h/%h expected %h/%h", c, o_data[0], o_data[1], rexp[0], mhead(1));
            end
        end
    endtask

    task automatic test_full_empty();
        tick(1'b1, 1'b0, 8'h00, 1'b0);
        for (int k = 0; k < 8; k++) tick(1'b0, 1'b1, 8'(8'h40 + k), 1'b0);
        tick(1'b0, 1'b1, 8'hFF, 1'b1);
        checks++;
        if (o_count[0] !== 4'd7 || o_ovf[0] !== 1'b1 || o_data[0] !== 8'h40) begin
            errors++; $display("FAIL full_rw_a count=%0d ovf=%b data=%h expected 7 1 40", o_count[0], o_ovf[0], o_data[0]);
        end
        checks++;
        if (o_count[1] !== 4'd4 || o_ovf[1] !== 1'b1 || o_data[1] !== 8'h41) begin
            errors++; $display("FAIL full_rw_b count=%0d ovf=%b head=%h expected 4 1 41", o_count[1], o_ovf[1], o_data[1]);
        end
        tick(1'b1, 1'b0, 8'h00, 1'b0);
        tick(1'b0, 1'b1, 8'h5A, 1'b1);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (o_count[i] !== 4'd1 || o_unf[i] !== 1'b1 || o_ovf[i] !== 1'b0 || o_empty[i] !== 1'b0) begin
                errors++; $display("FAIL empty_rw[%0d] count=%0d unf=%b ovf=%b empty=%b expected 1 1 0 0",
                                   i, o_count[i], o_unf[i], o_ovf[i], o_empty[i]);
            end
        end
        checks++;
        if (o_data[1] !== 8'h5A) begin errors++; $display("FAIL empty_rw_head got %h expected 5a", o_data[1]); end
    endtask

    task automatic test_flush();
        for (int k = 0; k < 4; k++) tick(1'b0, 1'b1, 8'(8'h60 + k), 1'b0);
        tick(1'b1, 1'b1, 8'hEE, 1'b0);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (o_count[i] !== 4'd0 || {o_empty[i], o_ae[i], o_full[i], o_af[i], o_ovf[i], o_unf[i]} !== 6'b110000) begin
                errors++; $display("FAIL flush_state[%0d] count=%0d e/ae/f/af/ovf/unf=%b expected 0 110000", i, o_count[i],
                                   {o_empty[i], o_ae[i], o_full[i], o_af[i], o_ovf[i], o_unf[i]});
            end
        end
        tick(1'b0, 1'b1, 8'h3C, 1'b0);
        checks++;
        if (o_data[1] !== 8'h3C) begin errors++; $display("FAIL flush_fwft_head got %h expected 3c", o_data[1]); end
        tick(1'b0, 1'b0, 8'h00, 1'b1);
        checks++;
        if (o_data[0] !== 8'h3C || o_empty[0] !== 1'b1) begin
            errors++; $display("FAIL flush_discard data=%h empty=%b expected 3c 1", o_data[0], o_empty[0]);
        end
    endtask

    task automatic test_async_reset();
        for (int k = 0; k < 3; k++) tick(1'b0, 1'b1, 8'($urandom), 1'b0);
        wr_en = 1'b1; wr_data = 8'h99;
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({o_full[i], o_empty[i], o_af[i], o_ae[i], o_ovf[i], o_unf[i]} !== 6'b010100 || o_count[i] !== 4'd0) begin
                errors++; $display("FAIL async_reset[%0d] flags=%b count=%0d expected 010100 0", i,
                                   {o_full[i], o_empty[i], o_af[i], o_ae[i], o_ovf[i], o_unf[i]}, o_count[i]);
            end
        end
        checks++;
        if (o_data[0] !== 8'h00) begin errors++; $display("FAIL async_reset_data got %h expected 00", o_data[0]); end
        @(negedge clk);
        wr_en = 1'b0;
        rst_n = 1'b1;
        model_clear();
        tick(1'b0, 1'b1, 8'hC3, 1'b0);
        tick(1'b0, 1'b1, 8'h3C, 1'b0);
        checks++;
        if (o_count[0] !== 4'd2 || o_count[1] !== 4'd2 || o_data[1] !== 8'hC3) begin
            errors++; $display("FAIL resume count=%0d/%0d head=%h expected 2/2 c3", o_count[0], o_count[1], o_data[1]);
        end
        tick(1'b0, 1'b0, 8'h00, 1'b1);
        checks++;
        if (o_data[0] !== 8'hC3) begin errors++; $display("FAIL resume_read got %h expected c3", o_data[0]); end
    endtask

    task automatic test_random();
        int n;
        bit we, re, fl;
        logic [5:0] fa, fe;
        for (int c = 0; c < 600; c++) begin
            fl = ($urandom_range(0, 99) < 2);
            we = ($urandom_range(0, 99) < ((c % 200) < 100 ? 75 : 30));
            re = ($urandom_range(0, 99) < ((c % 200) < 100 ? 30 : 75));
            tick(fl, we, 8'($urandom), re);
            for (int i = 0; i < 2; i++) begin
                n  = msize(i);
                fa = {o_full[i], o_empty[i], o_af[i], o_ae[i], o_ovf[i], o_unf[i]};
                fe = {n == dep[i], n == 0, n >= afth[i], n <= aeth[i], movf[i], munf[i]};
                checks++;
                if (o_count[i] !== 4'(n) || fa !== fe) begin
                    errors++; $display("FAIL rand_state[%0d] c=%0d count=%0d flags=%b expected %0d %b", i, c, o_count[i], fa, n, fe);
                end
            end
            checks++;
            if (o_data[0] !== rexp[0]) begin errors++; $display("FAIL rand_std_data c=%0d got %h expected %h", c, o_data[0], rexp[0]); end
            if (msize(1) != 0) begin
                checks++;
                if (o_data[1] !== mhead(1)) begin errors++; $display("FAIL rand_fwft_head c=%0d got %h expected %h", c, o_data[1], mhead(1)); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_back_to_back();
        test_full_empty();
        test_flush();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end
endmodule
